// File: rtl/fpu_pack.sv
// IEEE 754 binary32 field packer with a registered FCLASS stage.
// ieee_out is pure wiring; ieee_q/class_q capture on in_valid.
module fpu_pack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sign,
    input  logic [7:0]  exponent,
    input  logic [22:0] mantissa,
    input  logic        in_valid,
    output logic [31:0] ieee_out,
    output logic [31:0] ieee_q,
    output logic [9:0]  class_q,
    output logic        out_valid
);

    logic       exp_max;
    logic       exp_zero;
    logic       man_zero;
    logic [9:0] cls;

    assign ieee_out = {sign, exponent, mantissa};
    assign exp_max  = (exponent == 8'hFF);
    assign exp_zero = (exponent == 8'h00);
    assign man_zero = (mantissa == 23'h0);

    // Arms are mutually exclusive, so exactly one class bit is set.
    always_comb begin
        cls = '0;
        unique case (1'b1)
            exp_max && mantissa[22]:
                cls[9] = 1'b1;
            exp_max && !man_zero && !mantissa[22]:
                cls[8] = 1'b1;
            exp_max && man_zero:
                cls[sign ? 4'd0 : 4'd7] = 1'b1;
            exp_zero && man_zero:
                cls[sign ? 4'd3 : 4'd4] = 1'b1;
            exp_zero && !man_zero:
                cls[sign ? 4'd2 : 4'd5] = 1'b1;
            default:
                cls[sign ? 4'd1 : 4'd6] = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ieee_q    <= 32'h0;
            class_q   <= 10'h0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                ieee_q  <= ieee_out;
                class_q <= cls;
            end
        end
    end

endmodule

// File: tb/tb_fpu_pack.sv
// Scoreboard bench for fpu_pack: stimulus pushes expectations,
// a negedge monitor pops them whenever out_valid is presented.
module tb_fpu_pack;

    typedef struct {
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        logic [31:0] w;
        logic [9:0]  c;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
    logic        in_valid;
    logic [31:0] ieee_out;
    logic [31:0] ieee_q;
    logic [9:0]  class_q;
    logic        out_valid;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 1'b1;

    fpu_pack dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sign     (sign),
        .exponent (exponent),
        .mantissa (mantissa),
        .in_valid (in_valid),
        .ieee_out (ieee_out),
        .ieee_q   (ieee_q),
        .class_q  (class_q),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h",
                     name, act, req);
        end
    endtask

    // Apply inputs, check the combinational word, queue the capture.
    task automatic drive(input vec_t v, input logic vld);
        sign     = v.s;
        exponent = v.e;
        mantissa = v.m;
        in_valid = vld;
        if (vld) sb.push_back(v);
        #1;
        check("ieee_out", ieee_out, v.w);
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n === 1'b1 && out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                vec_t x;
                x = sb.pop_front();
                check("ieee_q", ieee_q, x.w);
                check("class_q", {22'h0, class_q}, {22'h0, x.c});
            end
        end
    end

    initial begin
        vec_t one;
        vec_t t;
        one = '{1'b0, 8'd127, 23'h0, 32'h3F800000, 10'h040};

        vecs.push_back('{1'b0, 8'd127, 23'h000000, 32'h3F800000, 10'h040});
        vecs.push_back('{1'b1, 8'd127, 23'h000000, 32'hBF800000, 10'h002});
        vecs.push_back('{1'b0, 8'd128, 23'h490FDB, 32'h40490FDB, 10'h040});
        vecs.push_back('{1'b1, 8'd150, 23'h7ABCDE, 32'hCB7ABCDE, 10'h002});
        vecs.push_back('{1'b0, 8'd127, 23'h555555, 32'h3FD55555, 10'h040});
        vecs.push_back('{1'b1, 8'd0,   23'h000000, 32'h80000000, 10'h008});
        vecs.push_back('{1'b0, 8'd255, 23'h000000, 32'h7F800000, 10'h080});
        vecs.push_back('{1'b1, 8'd255, 23'h000000, 32'hFF800000, 10'h001});
        vecs.push_back('{1'b0, 8'd255, 23'h400000, 32'h7FC00000, 10'h200});
        vecs.push_back('{1'b0, 8'd255, 23'h200000, 32'h7FA00000, 10'h100});
        vecs.push_back('{1'b1, 8'd255, 23'h400000, 32'hFFC00000, 10'h200});
        vecs.push_back('{1'b0, 8'd0,   23'h000001, 32'h00000001, 10'h020});
        vecs.push_back('{1'b0, 8'd0,   23'h7FFFFF, 32'h007FFFFF, 10'h020});
        vecs.push_back('{1'b0, 8'd1,   23'h000000, 32'h00800000, 10'h040});
        vecs.push_back('{1'b0, 8'd254, 23'h7FFFFF, 32'h7F7FFFFF, 10'h040});
        vecs.push_back('{1'b1, 8'd1,   23'h000000, 32'h80800000, 10'h002});
        vecs.push_back('{1'b1, 8'd0,   23'h000001, 32'h80000001, 10'h004});
        vecs.push_back('{1'b1, 8'd255, 23'h000001, 32'hFF800001, 10'h100});

        rst_n = 1'b0;
        in_valid = 1'b0;
        sign = 1'b0;
        exponent = 8'h0;
        mantissa = 23'h0;
        #2;
        check("rst_ieee_q", ieee_q, 32'h0);
        check("rst_class_q", {22'h0, class_q}, 32'h0);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);

        // Combinational packing while held in reset: nothing queued.
        for (int i = 0; i < 5; i++) drive(vecs[i], 1'b0);
        check("rst_hold_valid", {31'h0, out_valid}, 32'h0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("no_capture_yet", {31'h0, out_valid}, 32'h0);

        // Streaming: every vector on consecutive edges.
        foreach (vecs[i]) begin
            drive(vecs[i], 1'b1);
            @(posedge clk); #1;
        end

        // Latency/hold with +1.0.
        drive(one, 1'b1);
        @(posedge clk); #1;
        check("pipe_valid", {31'h0, out_valid}, 32'h1);
        check("pipe_q", ieee_q, 32'h3F800000);
        t = vecs[3];
        drive(t, 1'b0);
        @(posedge clk); #1;
        check("hold_valid", {31'h0, out_valid}, 32'h0);
        check("hold_q", ieee_q, 32'h3F800000);
        check("hold_class", {22'h0, class_q}, 32'h040);

        // Asynchronous reset while out_valid=1.
        drive(vecs[8], 1'b1);
        @(posedge clk); #2;
        check("pre_rst_valid", {31'h0, out_valid}, 32'h1);
        mon_en = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("arst_ieee_q", ieee_q, 32'h0);
        check("arst_class_q", {22'h0, class_q}, 32'h0);
        check("arst_valid", {31'h0, out_valid}, 32'h0);
        drive(vecs[3], 1'b0);
        @(posedge clk); #1;
        check("arst_held_q", ieee_q, 32'h0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        check("post_rst_valid", {31'h0, out_valid}, 32'h0);
        check("post_rst_q", ieee_q, 32'h0);

        // Resume: three distinct inputs back to back.
        drive(vecs[2], 1'b1);
        @(posedge clk); #1;
        drive(vecs[9], 1'b1);
        @(posedge clk); #1;
        drive(vecs[15], 1'b1);
        @(posedge clk); #1;
        t = vecs[0];
        drive(t, 1'b0);

        for (int k = 0; k < 10 && sb.size() != 0; k++)
            @(posedge clk);
        @(posedge clk); #1;
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
